// File: rtl/add_req_pkg.sv
// Shared types for the adder request initiator: FSM states and default timeout.
package add_req_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} add_req_state_t;

  localparam int unsigned ADD_REQ_TIMEOUT_DEF = 4;

endpackage

// File: rtl/add_req_initiator.sv
// Initiator for a start/valid single-op adder: takes operand pairs upstream, pulses start,
// waits (bounded) for the adder's valid and returns sum or timeout error downstream.
module add_req_initiator
  import add_req_pkg::*;
#(
  parameter int unsigned W       = 20,
  parameter int unsigned TIMEOUT = ADD_REQ_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y,
  input  logic             valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_err,
  output logic [CNT_W-1:0] stray_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

  add_req_state_t   state, state_nxt;
  logic [CW-1:0]    wcnt, wcnt_nxt;
  logic [W-1:0]     a_nxt, b_nxt, sum_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] stray_nxt;

  // Handshake outputs decode straight from state, so reset removes start asynchronously.
  assign in_ready  = (state == IDLE);
  assign start     = (state == ISSUE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      a         <= '0;
      b         <= '0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      stray_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      out_sum   <= sum_nxt;
      out_err   <= err_nxt;
      stray_cnt <= stray_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    a_nxt     = a;
    b_nxt     = b;
    sum_nxt   = out_sum;
    err_nxt   = out_err;
    stray_nxt = stray_cnt;

    if (valid && (state != WAIT) && (stray_cnt != '1)) begin
      stray_nxt = stray_cnt + CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt     = in_a;
          b_nxt     = in_b;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // valid is checked before the limit so a result on the last allowed cycle wins.
        if (valid) begin
          sum_nxt   = y;
          err_nxt   = 1'b0;
          state_nxt = HOLD;
        end else if (wcnt == WCNT_LAST) begin
          sum_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          wcnt_nxt = wcnt + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n) start |=> !start);
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                  out_valid && !out_ready |=> $stable(out_sum));
  a_ready_idle:  assert property (@(posedge clk) disable iff (!rst_n) in_ready == (state == IDLE));

endmodule
